wb_dest_demux: RTL
==================

Name: wb_dest_demux

Overview:
- Write-back stage of the 16-bit accumulator datapath; the opposite direction of the ALU operand-B select, which picks memory or immediate into the ALU.
- Steers each ALU result to one of two destinations: the accumulator register (single cycle) or data memory (store with a req/ack handshake and a timeout).
- Sits between the ALU output and the data-memory write port. Control presents one result at a time with a valid/ready handshake.

Parameters:
- DATA_W, 16, width of ALU result, accumulator and memory write data.
- ADDR_W, 11, data-memory address width.
- TIMEOUT, 16, maximum cycles to wait for mem_ack; must be >= 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  a result is presented.
- in_ready  out  1  block can accept a result this cycle.
- alu_result  in  DATA_W  ALU output.
- addr  in  ADDR_W  store address; used only when sel_dest=1.
- sel_dest  in  1  0 = accumulator, 1 = data memory.
- acc  out  DATA_W  accumulator register value.
- acc_we  out  1  one-cycle pulse, high the cycle after the accumulator is updated.
- mem_addr  out  ADDR_W  registered store address.
- mem_wdata  out  DATA_W  registered store data.
- mem_we  out  1  store request; held high until ack or timeout.
- mem_ack  in  1  memory accepted the store.
- store_done  out  1  one-cycle pulse when a store completes with ack.
- err  out  1  sticky timeout flag.
- err_clr  in  1  clears err.

Behaviour:
- Reset values: acc=0, acc_we=0, mem_addr=0, mem_wdata=0, mem_we=0, store_done=0, err=0, state=IDLE, counter=0. With in_ready=1, reset takes effect on the edge where it is sampled.
- Reset mid-store: the store is abandoned. mem_we=0 the following cycle. No store_done, no err.
- States: IDLE and MEM_WAIT.
- in_ready = (state==IDLE). It is combinational from state only; no dependency on in_valid.
- Accept = in_valid && in_ready.
- IDLE, accept with sel_dest=0:
  - acc <= alu_result at the edge.
  - acc_we=1 for exactly the next cycle.
  - Stay in IDLE, so back-to-back accumulator writes sustain 1 per cycle.
- IDLE, accept with sel_dest=1:
  - mem_addr <= addr, mem_wdata <= alu_result, mem_we <= 1, counter <= 0.
  - Go to MEM_WAIT.
  - acc is unchanged.
- MEM_WAIT with mem_ack=1:
  - mem_we <= 0, store_done=1 for the next cycle.
  - Go to IDLE; a new result can be accepted the cycle after the ack.
- MEM_WAIT with mem_ack=0:
  - counter <= counter+1.
  - When counter==TIMEOUT-1 and still no ack: mem_we <= 0, err <= 1, go to IDLE, no store_done.
  - Total request duration at timeout is TIMEOUT cycles.
- mem_ack in the same cycle as the timeout condition: the ack wins. The store completes normally and err is not set.
- mem_ack while in IDLE: ignored.
- mem_addr and mem_wdata are stable for the whole request. They are only reloaded on the next store accept.
- err_clr=1 clears err at the edge. If err_clr is asserted in the same cycle a timeout sets err, set wins.
- err does not block operation; subsequent results are still accepted.
- in_valid while not ready: no state change. Control must hold the inputs until accepted.
- Counter width is clog2(TIMEOUT). There is no wrap-around, because the block exits MEM_WAIT at TIMEOUT-1.

Decomposition:
- Shared package holds:
  - DEST_ACC=1'b0 and DEST_MEM=1'b1 constants.
  - State encoding IDLE=1'b0, MEM_WAIT=1'b1.
  - Default DATA_W, ADDR_W and TIMEOUT values.
- One natural sub-module: wb_store_timer, holding the counter with load/clear/increment and a terminal-count flag.
- The accumulator register and FSM stay in the top module.

Test Plan:
- Reset, then sel_dest=0, alu_result=16'h1234, in_valid=1 for one cycle -> acc=16'h1234 after the edge; acc_we high for one cycle; in_ready stays 1.
- Three consecutive accumulator writes 16'h0001, 16'h0002, 16'h0003 -> acc tracks each value on successive cycles, with acc_we high for 3 consecutive cycles.
- Store with sel_dest=1, addr=11'h07F, alu_result=16'hBEEF; mem_ack on the 3rd cycle of mem_we -> mem_addr/mem_wdata are stable; mem_we is high for 3 cycles; store_done pulses once; in_ready=0 for the whole request; acc unchanged.
- Store with mem_ack never asserted, TIMEOUT=16 -> mem_we high for exactly 16 cycles; then err=1 and in_ready=1. err_clr=1 for one cycle -> err=0.
- Store with mem_ack arriving exactly in the 16th cycle -> normal completion: store_done=1, err stays 0.
- reset asserted in the 2nd cycle of MEM_WAIT -> next cycle mem_we=0, acc=0, err=0, no store_done, in_ready=1.

Source files
------------

// File: rtl/wb_dest_demux_pkg.sv
// Shared definitions for the write-back destination demux: destination
// codes, FSM state encoding and default sizing.
package wb_dest_demux_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 11;
    localparam int DEF_TIMEOUT = 16;

    // Destination select values carried on sel_dest.
    localparam logic DEST_ACC = 1'b0;
    localparam logic DEST_MEM = 1'b1;

    // IDLE accepts results; MEM_WAIT holds a store request open.
    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_store_timer.sv
// Store request timer: counts cycles spent waiting for mem_ack and flags the
// last allowed cycle. It never wraps because the owner leaves the wait state
// on terminal count.
module wb_store_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear takes priority over increment so a new request always starts at 0.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Terminal count: the request has been open for TIMEOUT cycles this cycle.
    assign tc = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_dest_demux.sv
// Write-back destination demux: steers each accepted ALU result either into
// the accumulator (single cycle) or out to data memory as a store request
// that completes on mem_ack or gives up after TIMEOUT cycles.
//
// Input handshake: a result transfers on a rising edge where in_valid and
// in_ready are both high. in_ready depends only on the FSM state, never on
// in_valid; control holds alu_result/addr/sel_dest steady until the transfer.
module wb_dest_demux
    import wb_dest_demux_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [ADDR_W-1:0] addr,
    input  logic              sel_dest,
    output logic [DATA_W-1:0] acc,
    output logic              acc_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic              store_done,
    output logic              err,
    input  logic              err_clr,
    output wb_state_e         dbg_state
);

    wb_state_e         state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              acc_we_q, acc_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              store_done_q, store_done_d;
    logic              err_q, err_d;

    logic              accept;
    logic              tmr_clear;
    logic              tmr_inc;
    logic              tmr_tc;

    wb_store_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .clear(tmr_clear),
        .inc  (tmr_inc),
        .tc   (tmr_tc)
    );

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready;

    // Next-state and datapath decisions; a timeout set on err overrides err_clr.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        acc_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = mem_we_q;
        store_done_d = 1'b0;
        err_d        = err_clr ? 1'b0 : err_q;
        tmr_clear    = 1'b0;
        tmr_inc      = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (sel_dest == DEST_ACC) begin
                        acc_d    = alu_result;
                        acc_we_d = 1'b1;
                    end else begin
                        mem_addr_d  = addr;
                        mem_wdata_d = alu_result;
                        mem_we_d    = 1'b1;
                        tmr_clear   = 1'b1;
                        state_d     = MEM_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                // An ack on the terminal cycle still completes the store.
                if (mem_ack) begin
                    mem_we_d     = 1'b0;
                    store_done_d = 1'b1;
                    state_d      = IDLE;
                end else if (tmr_tc) begin
                    mem_we_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = IDLE;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                mem_we_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any open store silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            acc_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            store_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            acc_we_q     <= acc_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            store_done_q <= store_done_d;
            err_q        <= err_d;
        end
    end

    assign acc        = acc_q;
    assign acc_we     = acc_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;
    assign store_done = store_done_q;
    assign err        = err_q;
    assign dbg_state  = state_q;

endmodule
